dual_fetch_queue: RTL and testbench
===================================

// Module: dual_fetch_queue
// PURPOSE
//   Fetch stage for the 2-wide core. Drives both imem read ports with PC and PC+1 and
//   buffers returned instruction pairs, tagged with their PCs, in a circular queue.
//   Presents up to two in-order instructions per cycle to the F/D latch / decode.
//   A redirect from the branch/jump resolution logic flushes the queue and restarts fetch.
// PARAMETERS
//   DEPTH     8    queue entries; even, >= 4
//   AW        12   imem address / PC width
//   IW        32   instruction width
// PORTS
//   clock           in   1    master clock; all state updates on rising edge
//   reset           in   1    asynchronous, active-high
//   address_imem_a  out  AW   fetch address, slot a (= pc)
//   address_imem_b  out  AW   fetch address, slot b (= pc+1, mod 2^AW)
//   rden_a          out  1    imem read enable, port a
//   rden_b          out  1    imem read enable, port b
//   q_imem_a        in   IW   instruction at address_imem_a
//   q_imem_b        in   IW   instruction at address_imem_b
//   redirect_valid  in   1    taken branch/jump: flush and refetch
//   redirect_pc     in   AW   new fetch PC
//   deq_count       in   2    instructions decode consumes this cycle (0..2)
//   out_valid_a     out  1    head entry valid
//   out_valid_b     out  1    head+1 entry valid (implies out_valid_a)
//   out_inst_a/_b   out  IW   head / head+1 instruction
//   out_pc_a/_b     out  AW   head / head+1 PC
//   q_count         out  clog2(DEPTH+1)  current occupancy
// BEHAVIOUR
//   - Reset: pc=0, head=tail=count=0, rden_a/b=0, all out_* = 0. Takes effect immediately.
//   - imem runs on ~clock: q_imem_* are valid before the rising edge ending the cycle
//     in which address and rden are driven. Fetch-to-enqueue latency is 0 cycles;
//     enqueue-to-out_valid latency is 1 cycle.
//   - Fetch when !redirect_valid && count <= DEPTH-2 (count before this cycle's dequeue).
//     In a fetch cycle: rden_a=rden_b=1; both words enqueued at tail, tail+1; pc += 2.
//     When not fetching: rden_a=rden_b=0, pc holds, nothing enqueued.
//   - Dequeue: head += deq_count, count -= deq_count, in the same cycle as any enqueue.
//     Next count = count + enq - deq. deq_count > valid outputs is illegal (assertion);
//     the RTL clamps deq_count to the number of valid outputs.
//   - Outputs are combinational reads of head/head+1; out_*_b is zero when out_valid_b=0.
//   - Pointers wrap modulo DEPTH; the pair may straddle the wrap. PC wraps 4095 -> 0;
//     address_imem_b = 0 when pc = 4095.
//   - Redirect has priority: count=head=tail=0, pc=redirect_pc, and this cycle's fetch and
//     dequeue are discarded. out_valid_a=0 next cycle; the first redirect-PC instruction
//     reaches the outputs 2 cycles after the redirect cycle.
//   - Reset asserted mid-operation drops all queued entries; no partial pair remains.
// CONFIGURATION
//   FQ_BRANCH_BREAK_EN defined: slot a is predecoded. If opcode[31:27] is j(00001),
//     bne(00010), jal(00011), jr(00100), blt(00110) or bex(10110), only slot a is
//     enqueued and pc += 1. The control-flow instruction is therefore always the younger
//     word of its fetch pair.
//   Not defined: both words are always enqueued and pc += 2. There is no predecode logic.
// STRUCTURE
//   - fq_pkg holds: queue entry typedef {pc[AW-1:0], inst[IW-1:0]}, the control-flow
//     opcode constants, and OPC_MSB/OPC_LSB.
//   - One sub-module, fq_ring: a DEPTH-entry circular buffer with 2 write ports and 2 read
//     ports, plus the head/tail/count logic. The top level holds the PC, fetch control,
//     redirect handling and predecode.
// TESTING
//   1. Reset, imem[0..7] = distinct words, deq_count=0 -> queue fills to 8 after 4 fetch
//      cycles; rden=0 from then on; pc=8.
//   2. Steady state with deq_count=2 every cycle -> out_pc_a = 0,2,4,... on consecutive
//      cycles after a 1-cycle fill delay.
//   3. redirect_valid with redirect_pc=0x100 while count=6 -> next cycle count=0 and
//      out_valid_a=0; two cycles later out_pc_a=0x100 and out_pc_b=0x101.
//   4. Start at pc=4094 -> pairs (4094,4095), then (0,1); with DEPTH=8 and deq_count=1
//      alternating with 0, the queue entries straddle the pointer wrap intact.
//   5. FQ_BRANCH_BREAK_EN with imem[4] = bne -> pair at pc=4 enqueues one entry;
//      the next fetch is at pc=5. Without the macro, both 4 and 5 are enqueued.
//   6. Reset pulsed asynchronously mid-cycle with count=5 -> out_valid_a=0 and
//      q_count=0 before the next clock edge; fetch resumes at pc=0.

Source files
------------

// File: rtl/fq_pkg.sv
// Purpose: shared entry type, opcode constants and predecode helper for the fetch queue.
// Latency: none (types and constants only).
// Backpressure: none.
//
// Contents: fq_entry_t {pc, inst}, control-flow opcode values, OPC_MSB/OPC_LSB,
// is_ctrl_flow() predecode helper (only used when FQ_BRANCH_BREAK_EN is defined).
package fq_pkg;

  localparam int FQ_AW   = 12;
  localparam int FQ_IW   = 32;

  // Opcode field position within an instruction word.
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

  localparam logic [OPC_W-1:0] OPC_J   = 5'b00001;
  localparam logic [OPC_W-1:0] OPC_BNE = 5'b00010;
  localparam logic [OPC_W-1:0] OPC_JAL = 5'b00011;
  localparam logic [OPC_W-1:0] OPC_JR  = 5'b00100;
  localparam logic [OPC_W-1:0] OPC_BLT = 5'b00110;
  localparam logic [OPC_W-1:0] OPC_BEX = 5'b10110;

  typedef struct packed {
    logic [FQ_AW-1:0] pc;
    logic [FQ_IW-1:0] inst;
  } fq_entry_t;

  function automatic logic is_ctrl_flow(input logic [OPC_W-1:0] opc);
    return (opc == OPC_J)   || (opc == OPC_BNE) || (opc == OPC_JAL) ||
           (opc == OPC_JR)  || (opc == OPC_BLT) || (opc == OPC_BEX);
  endfunction

endpackage

// File: rtl/fq_ring.sv
// Purpose: DEPTH-entry circular buffer, 2 write ports and 2 read ports, with head/tail/count.
// Latency: write-to-read 1 cycle; reads are combinational from head/head+1.
// Backpressure: none internally; the writer must only enqueue when space exists.
//
// Ports: clock, reset (async, active-high), flush (sync clear of pointers/count),
//   enq_n (0..2 entries written at tail, tail+1), enq_a/enq_b (entries),
//   deq_n (0..2, clamped to entries available), rd_vld_a/b, rd_a/rd_b (head, head+1;
//   zero when not valid), count (occupancy).
module fq_ring
  import fq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [1:0]                   enq_n,
  input  fq_entry_t                    enq_a,
  input  fq_entry_t                    enq_b,
  input  logic [1:0]                   deq_n,
  output logic                         rd_vld_a,
  output logic                         rd_vld_b,
  output fq_entry_t                    rd_a,
  output fq_entry_t                    rd_b,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fq_entry_t        mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [PW-1:0]    head_p1;
  logic [PW-1:0]    tail_p1;
  logic [1:0]       avail;
  logic [1:0]       deq_eff;
  logic [CW-1:0]    count_nxt;

  // Modulo-DEPTH pointer advance; DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] n);
    logic [PW:0] s;
    s = {1'b0, p} + {{(PW-1){1'b0}}, n};
    if (s >= (PW+1)'(DEPTH)) s = s - (PW+1)'(DEPTH);
    return s[PW-1:0];
  endfunction

  assign head_p1  = ptr_add(head, 2'd1);
  assign tail_p1  = ptr_add(tail, 2'd1);

  assign rd_vld_a = (count != '0);
  assign rd_vld_b = (count >= CW'(2));
  assign rd_a     = rd_vld_a ? mem[head]    : '0;
  assign rd_b     = rd_vld_b ? mem[head_p1] : '0;

  // Decode may never take more than is presented; clamp keeps the pointers sane if it does.
  assign avail     = rd_vld_b ? 2'd2 : {1'b0, rd_vld_a};
  assign deq_eff   = (deq_n > avail) ? avail : deq_n;
  assign count_nxt = count + CW'(enq_n) - CW'(deq_eff);

  always_ff @(posedge clock) begin
    if (!flush) begin
      if (enq_n >= 2'd1) mem[tail]    <= enq_a;
      if (enq_n >= 2'd2) mem[tail_p1] <= enq_b;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= ptr_add(head, deq_eff);
      tail  <= ptr_add(tail, enq_n);
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/dual_fetch_queue.sv
// Purpose: 2-wide fetch stage; reads imem at pc/pc+1 and queues {pc,inst} pairs for decode.
// Latency: fetch-to-enqueue 0 cycles (imem on ~clock); enqueue-to-out_valid 1 cycle.
// Backpressure: fetch stalls while occupancy > DEPTH-2; decode pulls 0..2 via deq_count.
//
// Ports: clock, reset (async, active-high); address_imem_a/b, rden_a/b, q_imem_a/b (imem);
//   redirect_valid/redirect_pc (flush + refetch); deq_count (decode consumption);
//   out_valid_a/b, out_inst_a/b, out_pc_a/b (head, head+1); q_count (occupancy).
// Optional feature: define FQ_BRANCH_BREAK_EN to end a fetch pair after a control-flow
//   instruction in slot a (only slot a is enqueued, pc advances by 1).
module dual_fetch_queue
  import fq_pkg::*;
#(
  parameter int DEPTH = 8,
  // Entry layout comes from fq_pkg; these must match FQ_AW/FQ_IW.
  parameter int AW    = FQ_AW,
  parameter int IW    = FQ_IW
) (
  input  logic                         clock,
  input  logic                         reset,
  output logic [AW-1:0]                address_imem_a,
  output logic [AW-1:0]                address_imem_b,
  output logic                         rden_a,
  output logic                         rden_b,
  input  logic [IW-1:0]                q_imem_a,
  input  logic [IW-1:0]                q_imem_b,
  input  logic                         redirect_valid,
  input  logic [AW-1:0]                redirect_pc,
  input  logic [1:0]                   deq_count,
  output logic                         out_valid_a,
  output logic                         out_valid_b,
  output logic [IW-1:0]                out_inst_a,
  output logic [IW-1:0]                out_inst_b,
  output logic [AW-1:0]                out_pc_a,
  output logic [AW-1:0]                out_pc_b,
  output logic [$clog2(DEPTH+1)-1:0]   q_count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [AW-1:0] pc;
  logic          fetch;
  logic [1:0]    enq_n;
  logic [1:0]    deq_n;
  fq_entry_t     enq_a;
  fq_entry_t     enq_b;
  fq_entry_t     rd_a;
  fq_entry_t     rd_b;

  // Occupancy is checked before this cycle's dequeue so two free slots are guaranteed.
  assign fetch          = !reset && !redirect_valid && (q_count <= CW'(DEPTH-2));
  assign rden_a         = fetch;
  assign rden_b         = fetch;
  assign address_imem_a = pc;
  assign address_imem_b = pc + AW'(1);

`ifdef FQ_BRANCH_BREAK_EN
  logic slot_a_cf;
  // A control-flow word in slot a closes the pair, so it is always the younger word.
  assign slot_a_cf = is_ctrl_flow(q_imem_a[OPC_MSB:OPC_LSB]);
  assign enq_n     = !fetch ? 2'd0 : (slot_a_cf ? 2'd1 : 2'd2);
`else
  assign enq_n     = fetch ? 2'd2 : 2'd0;
`endif

  assign enq_a = '{pc: address_imem_a, inst: q_imem_a};
  assign enq_b = '{pc: address_imem_b, inst: q_imem_b};
  assign deq_n = redirect_valid ? 2'd0 : deq_count;

  // pc advances by exactly the number of words enqueued.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)               pc <= '0;
    else if (redirect_valid) pc <= redirect_pc;
    else                     pc <= pc + AW'(enq_n);
  end

  fq_ring #(.DEPTH(DEPTH)) u_ring (
    .clock    (clock),
    .reset    (reset),
    .flush    (redirect_valid),
    .enq_n    (enq_n),
    .enq_a    (enq_a),
    .enq_b    (enq_b),
    .deq_n    (deq_n),
    .rd_vld_a (out_valid_a),
    .rd_vld_b (out_valid_b),
    .rd_a     (rd_a),
    .rd_b     (rd_b),
    .count    (q_count)
  );

  assign out_inst_a = rd_a.inst;
  assign out_pc_a   = rd_a.pc;
  assign out_inst_b = rd_b.inst;
  assign out_pc_b   = rd_b.pc;

  a_deq_legal: assert property (@(posedge clock) disable iff (reset)
    {1'b0, deq_count} <= ({2'b0, out_valid_a} + {2'b0, out_valid_b}));

endmodule

// File: tb/tb_dual_fetch_queue.sv
module tb_dual_fetch_queue;
  import fq_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = 12;
  localparam int IW    = 32;
  localparam int CW    = 4;
`ifdef FQ_BRANCH_BREAK_EN
  localparam bit CF_EN = 1'b1;
`else
  localparam bit CF_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] address_imem_a, address_imem_b;
  logic          rden_a, rden_b;
  logic [IW-1:0] q_imem_a = '0;
  logic [IW-1:0] q_imem_b = '0;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic [1:0]    deq_count;
  logic          out_valid_a, out_valid_b;
  logic [IW-1:0] out_inst_a, out_inst_b;
  logic [AW-1:0] out_pc_a, out_pc_b;
  logic [CW-1:0] q_count;

  always #5 clock = ~clock;

  dual_fetch_queue #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) dut (
    .clock(clock), .reset(reset),
    .address_imem_a(address_imem_a), .address_imem_b(address_imem_b),
    .rden_a(rden_a), .rden_b(rden_b),
    .q_imem_a(q_imem_a), .q_imem_b(q_imem_b),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .deq_count(deq_count),
    .out_valid_a(out_valid_a), .out_valid_b(out_valid_b),
    .out_inst_a(out_inst_a), .out_inst_b(out_inst_b),
    .out_pc_a(out_pc_a), .out_pc_b(out_pc_b),
    .q_count(q_count)
  );

  // Instruction memory clocked on the falling edge.
  logic [IW-1:0] imem [4096];
  always @(negedge clock) begin
    if (rden_a) q_imem_a <= imem[address_imem_a];
    if (rden_b) q_imem_b <= imem[address_imem_b];
  end

  fq_entry_t     sb[$];
  logic [AW-1:0] m_pc;
  logic          m_fetch;
  logic          m_redir;
  logic [1:0]    m_deq;
  logic [AW-1:0] m_rpc;
  int            n_total;
  int            n_pass;

  function automatic logic [IW-1:0] word_of(input int a);
    logic [11:0] x;
    x = 12'(a);
    return {8'hA5, x, ~x};
  endfunction

  function automatic bit is_cf_word(input logic [IW-1:0] w);
    logic [4:0] op;
    op = w[31:27];
    return CF_EN && (op == 5'b00001 || op == 5'b00010 || op == 5'b00011 ||
                     op == 5'b00100 || op == 5'b00110 || op == 5'b10110);
  endfunction

  // Drive one cycle's inputs and note what the queue should do at the coming edge.
  task automatic apply(input logic [1:0] deq, input logic redir, input logic [AW-1:0] rpc);
    deq_count      = deq;
    redirect_valid = redir;
    redirect_pc    = rpc;
    m_deq   = deq;
    m_redir = redir;
    m_rpc   = rpc;
    m_fetch = !redir && (sb.size() <= DEPTH-2);
    #1;
  endtask

  task automatic tick();
    fq_entry_t e;
    @(posedge clock);
    if (m_redir) begin
      sb.delete();
      m_pc = m_rpc;
    end else begin
      for (int i = 0; i < int'(m_deq); i++) if (sb.size() != 0) void'(sb.pop_front());
      if (m_fetch) begin
        e.pc = m_pc; e.inst = imem[m_pc]; sb.push_back(e);
        if (is_cf_word(imem[m_pc])) m_pc = m_pc + 12'd1;
        else begin
          e.pc = m_pc + 12'd1; e.inst = imem[e.pc]; sb.push_back(e);
          m_pc = m_pc + 12'd2;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    @(posedge clock); #1;
    n_total++; if (q_count !== 4'd0) $display("FAIL reset_count: got %0d want 0", q_count); else n_pass++;
    n_total++; if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0) $display("FAIL reset_valid: got %b%b want 00", out_valid_a, out_valid_b); else n_pass++;
    n_total++; if (out_pc_a !== '0 || out_inst_a !== '0 || out_pc_b !== '0 || out_inst_b !== '0) $display("FAIL reset_out: got pc %h/%h inst %h/%h want all 0", out_pc_a, out_pc_b, out_inst_a, out_inst_b); else n_pass++;
    n_total++; if (rden_a !== 1'b0 || rden_b !== 1'b0) $display("FAIL reset_rden: got %b%b want 00", rden_a, rden_b); else n_pass++;
    n_total++; if (address_imem_a !== 12'd0) $display("FAIL reset_pc: got %h want 000", address_imem_a); else n_pass++;
    reset = 1'b0;
    sb.delete();
    m_pc = '0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 6; i++) begin
      apply(2'd0, 1'b0, '0);
      n_total++; if (rden_a !== m_fetch || rden_b !== m_fetch) $display("FAIL fill_rden[%0d]: got %b%b want %b", i, rden_a, rden_b, m_fetch); else n_pass++;
      n_total++; if (address_imem_a !== m_pc || address_imem_b !== m_pc + 12'd1) $display("FAIL fill_addr[%0d]: got %h/%h want %h", i, address_imem_a, address_imem_b, m_pc); else n_pass++;
      tick();
      n_total++; if (q_count !== CW'(sb.size())) $display("FAIL fill_count[%0d]: got %0d want %0d", i, q_count, sb.size()); else n_pass++;
    end
    n_total++; if (q_count !== 4'd8) $display("FAIL fill_full: got %0d want 8", q_count); else n_pass++;
    n_total++; if (address_imem_a !== 12'd8 || rden_a !== 1'b0) $display("FAIL fill_stall: got pc %h rden %b want 008 0", address_imem_a, rden_a); else n_pass++;
    n_total++; if (out_pc_a !== 12'd0 || out_pc_b !== 12'd1 || out_inst_b !== word_of(1)) $display("FAIL fill_head: got %h/%h %h want 000/001 %h", out_pc_a, out_pc_b, out_inst_b, word_of(1)); else n_pass++;
  endtask

  task automatic test_stream();
    for (int i = 0; i < 10; i++) begin
      n_total++; if (out_pc_a !== 12'(2*i)) $display("FAIL stream_pc_a[%0d]: got %h want %h", i, out_pc_a, 12'(2*i)); else n_pass++;
      n_total++;
      if (sb.size() < 2 || out_valid_b !== 1'b1 || out_inst_a !== sb[0].inst || out_pc_b !== sb[1].pc || out_inst_b !== sb[1].inst)
        $display("FAIL stream_sb[%0d]: got %h %h/%h %h want %0d queued", i, out_pc_a, out_inst_a, out_pc_b, out_inst_b, sb.size());
      else n_pass++;
      apply(2'd2, 1'b0, '0);
      tick();
    end
    n_total++; if (q_count !== 4'd6) $display("FAIL stream_count: got %0d want 6", q_count); else n_pass++;
  endtask

  task automatic test_redirect();
    apply(2'd0, 1'b1, 12'h100);
    n_total++; if (rden_a !== 1'b0 || rden_b !== 1'b0) $display("FAIL redir_rden: got %b%b want 00", rden_a, rden_b); else n_pass++;
    tick();
    n_total++; if (q_count !== 4'd0 || out_valid_a !== 1'b0 || out_valid_b !== 1'b0) $display("FAIL redir_flush: got count %0d valid %b%b want 0 00", q_count, out_valid_a, out_valid_b); else n_pass++;
    apply(2'd0, 1'b0, '0);
    n_total++; if (address_imem_a !== 12'h100 || rden_a !== 1'b1) $display("FAIL redir_fetch: got %h %b want 100 1", address_imem_a, rden_a); else n_pass++;
    tick();
    n_total++; if (out_valid_a !== 1'b1 || out_pc_a !== 12'h100 || out_pc_b !== 12'h101) $display("FAIL redir_out: got %b %h/%h want 1 100/101", out_valid_a, out_pc_a, out_pc_b); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if (sb.size() < 2 || out_pc_a !== 12'h100 + 12'(2*i) || out_inst_a !== sb[0].inst || out_pc_b !== sb[1].pc || out_inst_b !== sb[1].inst)
        $display("FAIL redir_stream[%0d]: got %h %h/%h want %h", i, out_pc_a, out_inst_a, out_pc_b, 12'h100 + 12'(2*i));
      else n_pass++;
      apply(2'd2, 1'b0, '0);
      tick();
    end
  endtask

  task automatic test_wrap();
    fq_entry_t ea, eb;
    logic [1:0] n;
    apply(2'd0, 1'b1, 12'hFFF);
    tick();
    n_total++; if (address_imem_a !== 12'hFFF || address_imem_b !== 12'h000) $display("FAIL wrap_addr_fff: got %h/%h want fff/000", address_imem_a, address_imem_b); else n_pass++;
    apply(2'd0, 1'b0, '0);
    tick();
    n_total++; if (out_pc_a !== 12'hFFF || out_pc_b !== 12'h000 || out_inst_b !== word_of(0)) $display("FAIL wrap_pair_fff: got %h/%h %h want fff/000 %h", out_pc_a, out_pc_b, out_inst_b, word_of(0)); else n_pass++;
    apply(2'd0, 1'b1, 12'd4094);
    tick();
    n_total++; if (address_imem_a !== 12'd4094 || address_imem_b !== 12'd4095) $display("FAIL wrap_addr_ffe: got %h/%h want ffe/fff", address_imem_a, address_imem_b); else n_pass++;
    for (int i = 0; i < 24; i++) begin
      ea = (sb.size() > 0) ? sb[0] : '0;
      eb = (sb.size() > 1) ? sb[1] : '0;
      n_total++;
      if (out_valid_a !== (sb.size() > 0) || out_valid_b !== (sb.size() > 1) || out_pc_a !== ea.pc || out_inst_a !== ea.inst || out_pc_b !== eb.pc || out_inst_b !== eb.inst)
        $display("FAIL wrap_sb[%0d]: got %b%b %h %h/%h %h want %h %h/%h %h", i, out_valid_a, out_valid_b, out_pc_a, out_inst_a, out_pc_b, out_inst_b, ea.pc, ea.inst, eb.pc, eb.inst);
      else n_pass++;
      if (i == 2) begin
        n_total++; if (out_pc_a !== 12'hFFF || out_pc_b !== 12'h000) $display("FAIL wrap_straddle: got %h/%h want fff/000", out_pc_a, out_pc_b); else n_pass++;
      end
      n = (i % 2 == 1 && sb.size() > 0) ? 2'd1 : 2'd0;
      apply(n, 1'b0, '0);
      tick();
      n_total++; if (q_count !== CW'(sb.size())) $display("FAIL wrap_count[%0d]: got %0d want %0d", i, q_count, sb.size()); else n_pass++;
    end
  endtask

  task automatic test_branch_break();
    logic [1:0] n;
    imem[4] = {5'b00010, 27'd4};
    apply(2'd0, 1'b1, '0);
    tick();
    for (int i = 0; i < 3; i++) begin
      apply(2'd0, 1'b0, '0);
      tick();
    end
`ifdef FQ_BRANCH_BREAK_EN
    n_total++; if (address_imem_a !== 12'd5 || q_count !== 4'd5) $display("FAIL brk_split: got pc %h count %0d want 005 5", address_imem_a, q_count); else n_pass++;
`else
    n_total++; if (address_imem_a !== 12'd6 || q_count !== 4'd6) $display("FAIL brk_nosplit: got pc %h count %0d want 006 6", address_imem_a, q_count); else n_pass++;
`endif
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        n_total++; if (out_pc_a !== 12'd4 || out_pc_b !== 12'd5 || out_inst_a !== imem[4]) $display("FAIL brk_head: got %h/%h %h want 004/005 %h", out_pc_a, out_pc_b, out_inst_a, imem[4]); else n_pass++;
      end
      n_total++;
      if (sb.size() < 2 || out_pc_a !== sb[0].pc || out_inst_a !== sb[0].inst || out_pc_b !== sb[1].pc || out_inst_b !== sb[1].inst)
        $display("FAIL brk_sb[%0d]: got %h/%h want %0d queued", i, out_pc_a, out_pc_b, sb.size());
      else n_pass++;
      n = (sb.size() >= 2) ? 2'd2 : 2'(sb.size());
      apply(n, 1'b0, '0);
      tick();
    end
    imem[4] = word_of(4);
  endtask

  task automatic test_reset_async();
    apply(2'd0, 1'b1, '0);
    tick();
    for (int i = 0; i < 4; i++) begin
      apply(2'd0, 1'b0, '0);
      tick();
    end
    apply(2'd1, 1'b0, '0);
    tick();
    apply(2'd2, 1'b0, '0);
    tick();
    n_total++; if (q_count !== 4'd5) $display("FAIL arst_pre_count: got %0d want 5", q_count); else n_pass++;
    apply(2'd0, 1'b0, '0);
    #2;
    reset = 1'b1;
    #1;
    n_total++; if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0 || q_count !== 4'd0) $display("FAIL arst_clear: got %b%b count %0d want 00 0", out_valid_a, out_valid_b, q_count); else n_pass++;
    n_total++; if (rden_a !== 1'b0 || address_imem_a !== 12'd0) $display("FAIL arst_fetch: got rden %b pc %h want 0 000", rden_a, address_imem_a); else n_pass++;
    @(posedge clock); #1;
    reset = 1'b0;
    sb.delete();
    m_pc = '0;
    apply(2'd0, 1'b0, '0);
    n_total++; if (address_imem_a !== 12'd0 || rden_a !== 1'b1) $display("FAIL arst_resume: got %h %b want 000 1", address_imem_a, rden_a); else n_pass++;
    tick();
    n_total++; if (out_pc_a !== 12'd0 || out_pc_b !== 12'd1 || q_count !== 4'd2 || out_inst_a !== sb[0].inst) $display("FAIL arst_out: got %h/%h count %0d want 000/001 2", out_pc_a, out_pc_b, q_count); else n_pass++;
  endtask

  initial begin
    reset          = 1'b1;
    deq_count      = 2'd0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    n_total = 0;
    n_pass  = 0;
    m_pc    = '0;
    m_fetch = 1'b0;
    m_redir = 1'b0;
    m_deq   = 2'd0;
    m_rpc   = '0;
    for (int i = 0; i < 4096; i++) imem[i] = word_of(i);
    test_reset();
    test_fill();
    test_stream();
    test_redirect();
    test_wrap();
    test_branch_break();
    test_reset_async();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
